id_operand_stage: RTL and testbench

Parametrised instruction-decode operand stage for the five-stage pipeline. It holds the register file with write-back bypass, resolves branch conditions and targets in ID, and detects load-use hazards with a configurable multi-cycle stall counter. It also owns the ID/EX pipeline register, including bubble insertion and flush. It sits between the IF/ID register and the EX stage and replaces the fixed 32×32, single-stall-cycle operand path.

---
 rtl/id_operand_stage.sv | 156 +++++++++++++++
 tb/tb_id_operand_stage.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/id_operand_stage.sv
// ID operand stage: register file with WB bypass, branch resolve, load-use stall FSM, ID/EX register.
// Optional: define ID_BR_HAZARD_EN to stall branches whose operands are pending EX ALU results.
module id_operand_stage #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned NREG     = 32,
    parameter int unsigned LOAD_LAT = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [31:0]                instr_id,
    input  logic [31:0]                next_pc_id,
    input  logic                       valid_id,
    input  logic                       uses_rs,
    input  logic                       uses_rt,
    input  logic [2:0]                 br_op,
    input  logic                       reg_write_wb,
    input  logic [$clog2(NREG)-1:0]    reg_waddr_wb,
    input  logic [DATA_W-1:0]          reg_wdata_wb,
    input  logic                       mem_read_ex,
    input  logic                       reg_write_ex,
    input  logic [$clog2(NREG)-1:0]    reg_waddr_ex,
    input  logic                       flush,
    output logic                       stall,
    output logic                       pc_if_write,
    output logic                       branch_taken,
    output logic [31:0]                branch_addr,
    output logic                       ex_valid,
    output logic [DATA_W-1:0]          ex_rs_data,
    output logic [DATA_W-1:0]          ex_rt_data,
    output logic [DATA_W-1:0]          ex_imm,
    output logic [$clog2(NREG)-1:0]    ex_rs_addr,
    output logic [$clog2(NREG)-1:0]    ex_rt_addr,
    output logic [$clog2(NREG)-1:0]    ex_rd_addr,
    output logic [31:0]                ex_next_pc
);
    localparam int unsigned AW = $clog2(NREG);

    typedef enum logic [0:0] {StIdle, StHold} state_e;

    state_e            state_q;
    logic [1:0]        cnt_q;
    logic [DATA_W-1:0] rf_q [NREG];

    logic [AW-1:0]     rs_addr, rt_addr, rd_addr;
    logic [DATA_W-1:0] rs_data, rt_data, imm_ext;
    logic              br_cond, hz, br_hz, rs_match, rt_match;

    assign rs_addr = AW'(instr_id[25:21]);
    assign rt_addr = AW'(instr_id[20:16]);
    assign rd_addr = AW'(instr_id[15:11]);
    assign imm_ext = DATA_W'($signed(instr_id[15:0]));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                rf_q[i] <= '0;
            end
        end else if (reg_write_wb && reg_waddr_wb != '0) begin
            rf_q[reg_waddr_wb] <= reg_wdata_wb;
        end
    end

    // WB bypass so a same-cycle write is visible to both operands and the branch compare.
    always_comb begin
        rs_data = rf_q[rs_addr];
        rt_data = rf_q[rt_addr];
        if (reg_write_wb && reg_waddr_wb == rs_addr) rs_data = reg_wdata_wb;
        if (reg_write_wb && reg_waddr_wb == rt_addr) rt_data = reg_wdata_wb;
        if (rs_addr == '0) rs_data = '0;
        if (rt_addr == '0) rt_data = '0;
    end

    always_comb begin
        br_cond = 1'b0;
        case (br_op)
            3'd1:    br_cond = (rs_data == rt_data);
            3'd2:    br_cond = (rs_data != rt_data);
            3'd3:    br_cond = ~rs_data[DATA_W-1];
            3'd4:    br_cond = ~rs_data[DATA_W-1] & (|rs_data);
            3'd5:    br_cond = rs_data[DATA_W-1] | ~(|rs_data);
            3'd6:    br_cond = rs_data[DATA_W-1];
            default: br_cond = 1'b0;
        endcase
    end

    assign rs_match = uses_rs & (rs_addr == reg_waddr_ex);
    assign rt_match = uses_rt & (rt_addr == reg_waddr_ex);
    assign hz = valid_id & mem_read_ex & (reg_waddr_ex != '0) & (rs_match | rt_match);

`ifdef ID_BR_HAZARD_EN
    assign br_hz = (br_op != 3'd0) & reg_write_ex & (reg_waddr_ex != '0) & (rs_match | rt_match);
`else
    assign br_hz = 1'b0;
`endif

    assign stall        = (state_q == StHold) | ((state_q == StIdle) & (hz | br_hz));
    assign pc_if_write  = ~stall;
    assign branch_taken = valid_id & ~stall & ~flush & br_cond;
    assign branch_addr  = next_pc_id + {{14{instr_id[15]}}, instr_id[15:0], 2'b00};

    // HOLD covers the remaining LOAD_LAT-1 cycles; hz is not re-sampled while holding.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else if (flush) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (hz && LOAD_LAT > 1) begin
                        state_q <= StHold;
                        cnt_q   <= 2'(LOAD_LAT - 1);
                    end
                end
                StHold: begin
                    cnt_q <= cnt_q - 2'd1;
                    if (cnt_q == 2'd1) state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst || flush) begin
            ex_valid   <= 1'b0;
            ex_rs_data <= '0;
            ex_rt_data <= '0;
            ex_imm     <= '0;
            ex_rs_addr <= '0;
            ex_rt_addr <= '0;
            ex_rd_addr <= '0;
            ex_next_pc <= '0;
        end else if (stall) begin
            ex_valid <= 1'b0;
        end else begin
            ex_valid   <= valid_id;
            ex_rs_data <= rs_data;
            ex_rt_data <= rt_data;
            ex_imm     <= imm_ext;
            ex_rs_addr <= rs_addr;
            ex_rt_addr <= rt_addr;
            ex_rd_addr <= rd_addr;
            ex_next_pc <= next_pc_id;
        end
    end

    logic unused_inputs;
    assign unused_inputs = ^{instr_id[31:26], reg_write_ex};

endmodule

// File: tb/tb_id_operand_stage.sv
// Scoreboard bench for id_operand_stage (LOAD_LAT=3); expected ID/EX contents queued per cycle.
module tb_id_operand_stage;
    localparam int unsigned LL = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr_id, next_pc_id;
    logic        valid_id, uses_rs, uses_rt;
    logic [2:0]  br_op;
    logic        reg_write_wb;
    logic [4:0]  reg_waddr_wb;
    logic [31:0] reg_wdata_wb;
    logic        mem_read_ex, reg_write_ex;
    logic [4:0]  reg_waddr_ex;
    logic        flush;
    logic        stall, pc_if_write, branch_taken;
    logic [31:0] branch_addr;
    logic        ex_valid;
    logic [31:0] ex_rs_data, ex_rt_data, ex_imm, ex_next_pc;
    logic [4:0]  ex_rs_addr, ex_rt_addr, ex_rd_addr;

    always #5 clk = ~clk;

    id_operand_stage #(.DATA_W(32), .NREG(32), .LOAD_LAT(LL)) dut (
        .clk(clk), .rst(rst), .instr_id(instr_id), .next_pc_id(next_pc_id),
        .valid_id(valid_id), .uses_rs(uses_rs), .uses_rt(uses_rt), .br_op(br_op),
        .reg_write_wb(reg_write_wb), .reg_waddr_wb(reg_waddr_wb), .reg_wdata_wb(reg_wdata_wb),
        .mem_read_ex(mem_read_ex), .reg_write_ex(reg_write_ex), .reg_waddr_ex(reg_waddr_ex),
        .flush(flush), .stall(stall), .pc_if_write(pc_if_write), .branch_taken(branch_taken),
        .branch_addr(branch_addr), .ex_valid(ex_valid), .ex_rs_data(ex_rs_data),
        .ex_rt_data(ex_rt_data), .ex_imm(ex_imm), .ex_rs_addr(ex_rs_addr),
        .ex_rt_addr(ex_rt_addr), .ex_rd_addr(ex_rd_addr), .ex_next_pc(ex_next_pc)
    );

    typedef struct packed {
        logic        v;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] imm;
        logic [4:0]  rsa;
        logic [4:0]  rta;
        logic [4:0]  rda;
        logic [31:0] npc;
    } ex_t;

    ex_t         sb[$];
    ex_t         ex_hold;
    logic [31:0] mrf [32];
    int          n_checks = 0;
    int          n_fail = 0;
    logic        exp_bh;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] rdm(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (reg_write_wb && reg_waddr_wb == a) return reg_wdata_wb;
        return mrf[a];
    endfunction

    task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [15:0] imm, input logic [31:0] npc,
                          input logic urs, input logic urt, input logic [2:0] br);
        valid_id   = v;
        instr_id   = {6'd0, rs, rt, imm};
        next_pc_id = npc;
        uses_rs    = urs;
        uses_rt    = urt;
        br_op      = br;
    endtask

    // Check combinational outputs, queue the expected ID/EX contents, clock, then compare.
    task automatic step(input string tag, input logic exp_stall, input logic exp_br);
        ex_t e;
        #2;
        check_eq({tag, "_stall"}, stall, exp_stall);
        check_eq({tag, "_pcw"}, pc_if_write, !exp_stall);
        check_eq({tag, "_br"}, branch_taken, exp_br);
        check_eq({tag, "_baddr"}, branch_addr,
                 next_pc_id + {{14{instr_id[15]}}, instr_id[15:0], 2'b00});
        if (flush) begin
            e = '0;
        end else if (exp_stall) begin
            e   = ex_hold;
            e.v = 1'b0;
        end else begin
            e.v   = valid_id;
            e.rs  = rdm(instr_id[25:21]);
            e.rt  = rdm(instr_id[20:16]);
            e.imm = {{16{instr_id[15]}}, instr_id[15:0]};
            e.rsa = instr_id[25:21];
            e.rta = instr_id[20:16];
            e.rda = instr_id[15:11];
            e.npc = next_pc_id;
        end
        sb.push_back(e);
        if (reg_write_wb && reg_waddr_wb != 5'd0) mrf[reg_waddr_wb] = reg_wdata_wb;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check_eq({tag, "_sbempty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check_eq({tag, "_exv"}, ex_valid, e.v);
            check_eq({tag, "_exrs"}, ex_rs_data, e.rs);
            check_eq({tag, "_exrt"}, ex_rt_data, e.rt);
            check_eq({tag, "_eximm"}, ex_imm, e.imm);
            check_eq({tag, "_exaddr"}, {ex_rs_addr, ex_rt_addr, ex_rd_addr}, {e.rsa, e.rta, e.rda});
            check_eq({tag, "_exnpc"}, ex_next_pc, e.npc);
            ex_hold = e;
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mrf[i] = 32'd0;
        ex_hold = '0;
        rst = 1'b1;
        set_id(1'b0, 5'd0, 5'd0, 16'h0, 32'h0, 1'b0, 1'b0, 3'd0);
        reg_write_wb = 1'b0; reg_waddr_wb = 5'd0; reg_wdata_wb = 32'd0;
        mem_read_ex = 1'b0; reg_write_ex = 1'b0; reg_waddr_ex = 5'd0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_exv", ex_valid, 32'd0);
        check_eq("rst_exrs", ex_rs_data, 32'd0);
        check_eq("rst_exnpc", ex_next_pc, 32'd0);
        check_eq("rst_stall", stall, 32'd0);
        rst = 1'b0;

        // Register file write/read and r0
        reg_write_wb = 1'b1; reg_waddr_wb = 5'd5; reg_wdata_wb = 32'h12345678;
        step("wb_r5", 1'b0, 1'b0);
        reg_waddr_wb = 5'd0; reg_wdata_wb = 32'hFFFFFFFF;
        set_id(1'b1, 5'd5, 5'd0, 16'h0804, 32'h100, 1'b1, 1'b0, 3'd0);
        step("rd_r5", 1'b0, 1'b0);
        check_eq("r5_const", ex_rs_data, 32'h12345678);
        reg_write_wb = 1'b0;
        set_id(1'b1, 5'd0, 5'd5, 16'h8000, 32'h104, 1'b1, 1'b1, 3'd0);
        step("rd_r0", 1'b0, 1'b0);
        check_eq("r0_const", ex_rs_data, 32'd0);

        // WB bypass into operands and branch compare
        reg_write_wb = 1'b1; reg_waddr_wb = 5'd3; reg_wdata_wb = 32'hA5A5A5A5;
        set_id(1'b1, 5'd3, 5'd3, 16'h0008, 32'h200, 1'b1, 1'b1, 3'd1);
        step("byp_beq", 1'b0, 1'b1);
        check_eq("byp_const", ex_rt_data, 32'hA5A5A5A5);
        reg_write_wb = 1'b0;
        set_id(1'b1, 5'd3, 5'd5, 16'h0008, 32'h204, 1'b1, 1'b1, 3'd2);
        step("bne", 1'b0, 1'b1);
        set_id(1'b1, 5'd3, 5'd5, 16'h0008, 32'h208, 1'b1, 1'b1, 3'd1);
        step("beq_ne", 1'b0, 1'b0);

        // Branch target and signed conditions
        reg_write_wb = 1'b1; reg_waddr_wb = 5'd9; reg_wdata_wb = 32'h80000000;
        set_id(1'b1, 5'd0, 5'd0, 16'hFFFE, 32'h00400010, 1'b0, 1'b0, 3'd0);
        step("btgt", 1'b0, 1'b0);
        check_eq("btgt_const", branch_addr, 32'h00400008);
        reg_write_wb = 1'b0;
        set_id(1'b1, 5'd9, 5'd0, 16'h0010, 32'h300, 1'b1, 1'b0, 3'd6);
        step("bltz", 1'b0, 1'b1);
        set_id(1'b1, 5'd0, 5'd0, 16'h0010, 32'h304, 1'b1, 1'b0, 3'd4);
        step("bgtz0", 1'b0, 1'b0);
        set_id(1'b1, 5'd0, 5'd0, 16'h0010, 32'h308, 1'b1, 1'b0, 3'd3);
        step("bgez0", 1'b0, 1'b1);
        set_id(1'b1, 5'd9, 5'd0, 16'h0010, 32'h30C, 1'b1, 1'b0, 3'd5);
        step("blez", 1'b0, 1'b1);
        set_id(1'b1, 5'd9, 5'd0, 16'h0010, 32'h310, 1'b1, 1'b0, 3'd3);
        step("bgez_neg", 1'b0, 1'b0);
        set_id(1'b1, 5'd3, 5'd3, 16'h0010, 32'h314, 1'b1, 1'b1, 3'd7);
        step("brsvd", 1'b0, 1'b0);
        set_id(1'b1, 5'd0, 5'd0, 16'h0001, 32'hFFFFFFFC, 1'b0, 1'b0, 3'd0);
        step("bwrap", 1'b0, 1'b0);
        check_eq("bwrap_const", branch_addr, 32'd0);

        // Load-use hazard: exactly LL stall cycles
        set_id(1'b1, 5'd7, 5'd2, 16'h0020, 32'h400, 1'b1, 1'b1, 3'd0);
        mem_read_ex = 1'b1; reg_waddr_ex = 5'd7;
        step("lu0", 1'b1, 1'b0);
        mem_read_ex = 1'b0;
        step("lu1", 1'b1, 1'b0);
        step("lu2", 1'b1, 1'b0);
        step("lu3", 1'b0, 1'b0);
        set_id(1'b1, 5'd2, 5'd7, 16'h0024, 32'h404, 1'b1, 1'b0, 3'd0);
        mem_read_ex = 1'b1;
        step("lu_nouse", 1'b0, 1'b0);
        set_id(1'b1, 5'd0, 5'd0, 16'h0028, 32'h408, 1'b1, 1'b1, 3'd0);
        reg_waddr_ex = 5'd0;
        step("lu_r0", 1'b0, 1'b0);
        mem_read_ex = 1'b0;

        // Flush in the second stall cycle aborts the hold
        set_id(1'b1, 5'd7, 5'd2, 16'h0030, 32'h500, 1'b1, 1'b1, 3'd0);
        mem_read_ex = 1'b1; reg_waddr_ex = 5'd7;
        step("fl0", 1'b1, 1'b0);
        mem_read_ex = 1'b0; flush = 1'b1;
        step("fl1", 1'b1, 1'b0);
        flush = 1'b0;
        step("fl2", 1'b0, 1'b0);

        // Flush and hazard together: stall visible, nothing recorded
        mem_read_ex = 1'b1; flush = 1'b1;
        step("flhz0", 1'b1, 1'b0);
        mem_read_ex = 1'b0; flush = 1'b0;
        step("flhz1", 1'b0, 1'b0);

        // Branch on a pending EX ALU result
`ifdef ID_BR_HAZARD_EN
        exp_bh = 1'b1;
`else
        exp_bh = 1'b0;
`endif
        set_id(1'b1, 5'd4, 5'd4, 16'h0002, 32'h600, 1'b1, 1'b1, 3'd1);
        reg_write_ex = 1'b1; reg_waddr_ex = 5'd4;
        step("brhz0", exp_bh, !exp_bh);
        reg_write_ex = 1'b0;
        step("brhz1", 1'b0, 1'b1);

        // Asynchronous reset while holding
        set_id(1'b1, 5'd7, 5'd5, 16'h0040, 32'h700, 1'b1, 1'b1, 3'd0);
        mem_read_ex = 1'b1; reg_waddr_ex = 5'd7;
        step("ar0", 1'b1, 1'b0);
        mem_read_ex = 1'b0;
        rst = 1'b1;
        #1;
        check_eq("ar_stall", stall, 32'd0);
        check_eq("ar_exv", ex_valid, 32'd0);
        check_eq("ar_exnpc", ex_next_pc, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 32; i++) mrf[i] = 32'd0;
        ex_hold = '0;
        set_id(1'b1, 5'd5, 5'd3, 16'h0044, 32'h704, 1'b1, 1'b1, 3'd0);
        step("ar1", 1'b0, 1'b0);
        check_eq("ar_r5", ex_rs_data, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
